// File: rtl/ptmch_pkg.sv
// Shared widths and defaults for the SPI pattern-match trigger block.
package ptmch_pkg;

  localparam int unsigned SPI_BYTE_W        = 8;
  localparam int unsigned BIT_CNT_W         = 4;
  localparam int unsigned PULSE_CNT_W       = 8;
  localparam int unsigned DEF_PULSE_WIDTH   = 4;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam logic [SPI_BYTE_W-1:0] DEF_MATCH_PATTERN = 8'h10;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/ptmch_spi_rx.sv
// SPI_CLK-domain receiver: captures the first byte of a mode-0, MSB-first frame.
// Shift register, bit counter and byte_valid clear while CS is high; rx_byte holds.
module ptmch_spi_rx
  import ptmch_pkg::*;
(
  input  logic                  spi_clk,
  input  logic                  rst_n,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic [SPI_BYTE_W-1:0] rx_byte,
  output logic                  byte_valid
);

  localparam bit_cnt_t BYTE_BITS = BIT_CNT_W'(SPI_BYTE_W);
  localparam bit_cnt_t LAST_BIT  = BIT_CNT_W'(SPI_BYTE_W - 1);

  logic                  clr_n;
  logic [SPI_BYTE_W-1:0] shift_q;
  logic [SPI_BYTE_W-1:0] shift_nxt_c;
  bit_cnt_t              bit_cnt;

  assign clr_n       = rst_n & ~spi_cs;
  assign shift_nxt_c = {shift_q[SPI_BYTE_W-2:0], spi_mosi};

  // Counter saturates at 8 so trailing clocks in the frame are ignored.
  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
    end else if (bit_cnt != BYTE_BITS) begin
      shift_q    <= shift_nxt_c;
      bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
      byte_valid <= (bit_cnt == LAST_BIT);
    end
  end

  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte <= '0;
    end else if (bit_cnt == LAST_BIT) begin
      rx_byte <= shift_nxt_c;
    end
  end

endmodule

// File: rtl/ptmch_top.sv
// SPI write-only pattern-match trigger: fires a PULSE_WIDTH-cycle TRG_PLS in CLK75M
// after a frame whose first byte matches MATCH_PATTERN. Option: PTMCH_MASK_EN adds MATCH_MASK.
module ptmch_top
  import ptmch_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] MATCH_PATTERN = DEF_MATCH_PATTERN,
  parameter int unsigned           PULSE_WIDTH   = DEF_PULSE_WIDTH,
  parameter int unsigned           SYNC_STAGES   = DEF_SYNC_STAGES
`ifdef PTMCH_MASK_EN
  ,
  parameter logic [SPI_BYTE_W-1:0] MATCH_MASK    = 8'hFF
`endif
) (
  input  logic CLK75M,
  input  logic RESET_N,
  input  logic SPI_CS,
  input  logic SPI_CLK,
  input  logic SPI_MOSI,
  output logic TRG_PLS
);

  logic [SPI_BYTE_W-1:0]  rx_byte;
  logic                   byte_valid;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   cs_last_d;
  logic                   bv_seen;
  logic                   match_q;
  logic                   byte_eq_c;
  logic                   frame_end_c;
  logic [PULSE_CNT_W-1:0] pulse_cnt;
  logic [PULSE_CNT_W-1:0] pulse_cnt_nxt_c;

  ptmch_spi_rx u_spi_rx (
    .spi_clk    (SPI_CLK),
    .rst_n      (RESET_N),
    .spi_cs     (SPI_CS),
    .spi_mosi   (SPI_MOSI),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid)
  );

`ifdef PTMCH_MASK_EN
  assign byte_eq_c = (rx_byte & MATCH_MASK) == (MATCH_PATTERN & MATCH_MASK);
`else
  assign byte_eq_c = (rx_byte == MATCH_PATTERN);
`endif

  // CS synchronizer; idle-high reset value keeps reset release from looking like a frame end.
  always_ff @(posedge CLK75M or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync   <= '1;
      cs_last_d <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      cs_last_d <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign frame_end_c = cs_sync[SYNC_STAGES-1] & ~cs_last_d;

  // byte_valid must be seen on two edges before rx_byte is trusted; the flag is
  // sticky so it survives byte_valid clearing when CS rises ahead of the chain.
  always_ff @(posedge CLK75M or negedge RESET_N) begin
    if (!RESET_N) begin
      bv_seen <= 1'b0;
      match_q <= 1'b0;
    end else begin
      bv_seen <= byte_valid;
      if (cs_sync[SYNC_STAGES-1]) begin
        match_q <= 1'b0;
      end else if (bv_seen && byte_eq_c) begin
        match_q <= 1'b1;
      end
    end
  end

  always_comb begin
    pulse_cnt_nxt_c = pulse_cnt;
    if (frame_end_c && match_q) begin
      pulse_cnt_nxt_c = PULSE_CNT_W'(PULSE_WIDTH);
    end else if (pulse_cnt != '0) begin
      pulse_cnt_nxt_c = pulse_cnt - PULSE_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK75M or negedge RESET_N) begin
    if (!RESET_N) begin
      pulse_cnt <= '0;
      TRG_PLS   <= 1'b0;
    end else begin
      pulse_cnt <= pulse_cnt_nxt_c;
      TRG_PLS   <= (pulse_cnt_nxt_c != '0);
    end
  end

endmodule

// File: tb/tb_ptmch_top.sv
// Randomized bench for ptmch_top: two instances (pulse width 4 and 20) share the SPI stimulus.
`timescale 1ns/1ps
module tb_ptmch_top;

  localparam logic [7:0]  PAT  = 8'h10;
  localparam int unsigned PW_A = 4;
  localparam int unsigned PW_B = 20;
`ifdef PTMCH_MASK_EN
  localparam logic [7:0]  MASK = 8'hF0;
`else
  localparam logic [7:0]  MASK = 8'hFF;
`endif

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic spi_cs   = 1'b1;
  logic spi_clk  = 1'b0;
  logic spi_mosi = 1'b0;
  logic trg_a;
  logic trg_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Expected pulse windows, in CLK75M posedge indices (inclusive).
  int from_a = 0, until_a = -1;
  int from_b = 0, until_b = -1;

`ifdef PTMCH_MASK_EN
  ptmch_top #(.MATCH_PATTERN(PAT), .PULSE_WIDTH(PW_A), .MATCH_MASK(MASK)) dut_a (
`else
  ptmch_top #(.MATCH_PATTERN(PAT), .PULSE_WIDTH(PW_A)) dut_a (
`endif
    .CLK75M(clk), .RESET_N(rst_n), .SPI_CS(spi_cs), .SPI_CLK(spi_clk),
    .SPI_MOSI(spi_mosi), .TRG_PLS(trg_a)
  );

`ifdef PTMCH_MASK_EN
  ptmch_top #(.MATCH_PATTERN(PAT), .PULSE_WIDTH(PW_B), .MATCH_MASK(MASK)) dut_b (
`else
  ptmch_top #(.MATCH_PATTERN(PAT), .PULSE_WIDTH(PW_B)) dut_b (
`endif
    .CLK75M(clk), .RESET_N(rst_n), .SPI_CS(spi_cs), .SPI_CLK(spi_clk),
    .SPI_MOSI(spi_mosi), .TRG_PLS(trg_b)
  );

  always #6.667 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t (cyc %0d)", tag, got, exp, $time, cyc);
    end
  endtask

  function automatic logic in_win(input int f, input int u);
    return (cyc >= f) && (cyc <= u);
  endfunction

  // Frame end observed now: a hit pulses from the 3rd CLK75M edge on; overlap merges windows.
  task automatic model_frame_end(input bit hit);
    int start;
    if (hit) begin
      start = cyc + 3;
      if (until_a < start - 1) from_a = start;
      until_a = start + int'(PW_A) - 1;
      if (until_b < start - 1) from_b = start;
      until_b = start + int'(PW_B) - 1;
    end
  endtask

  task automatic model_reset();
    until_a = -1;
    until_b = -1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("trg_a", trg_a, in_win(from_a, until_a));
      check("trg_b", trg_b, in_win(from_b, until_b));
    end
  end

  // One CS-low frame; CS rises just after a CLK75M negedge to stay clear of active edges.
  task automatic send_frame(input logic [7:0] b, input int nclk, input int gap_ns);
    logic [7:0] byte_v;
    byte_v = b;
    spi_cs = 1'b0;
    #5;
    for (int i = 0; i < nclk; i++) begin
      spi_mosi = (i < 8) ? byte_v[7-i] : 1'($urandom_range(1, 0));
      #10 spi_clk = 1'b1;
      #10 spi_clk = 1'b0;
    end
    #25;
    @(negedge clk);
    #1;
    spi_cs = 1'b1;
    model_frame_end((nclk >= 8) && ((byte_v & MASK) == (PAT & MASK)));
    #(gap_ns);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    // Reset with SPI idle
    #2 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    check("reset_trg_a", trg_a, 1'b0);
    check("reset_trg_b", trg_b, 1'b0);
    #100;
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(20);

    // Matching frame with trailing clocks
    send_frame(8'h10, 16, 200);
    // Non-matching then matching
    send_frame(8'h50, 16, 200);
    send_frame(8'h10, 16, 200);
    // Short frame, then full frame
    send_frame(8'h10, 5, 200);
    send_frame(8'h10, 16, 200);
    // Back-to-back short frames: second ends inside the 20-cycle pulse
    send_frame(8'h10, 8, 55);
    send_frame(8'h10, 8, 400);

    // Reset while the pulse is active drops TRG_PLS at once
    send_frame(8'h10, 16, 0);
    wait_cycles(5);
    #1;
    check("pre_reset_trg_b", trg_b, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_clr_trg_a", trg_a, 1'b0);
    check("async_clr_trg_b", trg_b, 1'b0);
    #100;
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(5);

    // Masked-compare candidate; exact compare rejects it
    send_frame(8'h1F, 16, 200);

    // Reset in the middle of a frame discards the partial byte
    spi_cs = 1'b0;
    #5;
    for (int i = 0; i < 4; i++) begin
      spi_mosi = PAT[7-i];
      #10 spi_clk = 1'b1;
      #10 spi_clk = 1'b0;
    end
    rst_n = 1'b0;
    model_reset();
    #20 spi_cs = 1'b1;
    #60;
    @(negedge clk);
    #1 rst_n = 1'b1;
    #60;
    send_frame(8'h10, 16, 200);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      rb = ($urandom_range(1, 0) != 0) ? PAT : 8'($urandom);
      send_frame(rb, int'($urandom_range(16, 4)), int'($urandom_range(300, 60)));
    end

    wait_cycles(40);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
